// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between the requester ports and the shared-resource arbiter.
interface rr_priority_arbiter_if;
  logic [7:0] req;
  logic       rr_mode;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       hold_expired;

  modport master (
    output req, rr_mode,
    input  gnt, gnt_idx, gnt_valid, hold_expired
  );

  modport slave (
    input  req, rr_mode,
    output gnt, gnt_idx, gnt_valid, hold_expired
  );
endinterface

// File: rtl/rr_priority_arbiter.sv
// 8-way arbiter: highest-index-wins with optional round-robin rotation,
// non-preemptive grant hold bounded by MAX_HOLD, one idle cycle between grants.
module rr_priority_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_priority_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state, w_state_n;
  logic [7:0] r_gnt, w_gnt_n;
  logic [2:0] r_idx, w_idx_n;
  logic [2:0] r_last, w_last_n;
  logic [7:0] r_hold, w_hold_n;
  logic       r_hx, w_hx_n;
  logic [7:0] w_masked;
  logic [2:0] w_win;

  function automatic logic [2:0] f_top(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_last  <= '0;
      r_hold  <= '0;
      r_hx    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_idx   <= w_idx_n;
      r_last  <= w_last_n;
      r_hold  <= w_hold_n;
      r_hx    <= w_hx_n;
    end
  end

  // Round-robin looks below the last winner first, then wraps to the full vector.
  always_comb begin
    w_masked = '0;
    for (int unsigned i = 0; i < 8; i++)
      w_masked[i] = bus.req[i] && (3'(i) < r_last);
    w_win = (bus.rr_mode && (|w_masked)) ? f_top(w_masked) : f_top(bus.req);
  end

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_idx_n   = r_idx;
    w_last_n  = r_last;
    w_hold_n  = r_hold;
    w_hx_n    = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_n  = '0;
        w_idx_n  = '0;
        w_hold_n = '0;
        if (|bus.req) begin
          w_state_n = GRANT;
          w_gnt_n   = 8'b1 << w_win;
          w_idx_n   = w_win;
          w_last_n  = w_win;
        end
      end
      GRANT: begin
        // A requester drop wins over expiry on the same edge: no pulse.
        if (!bus.req[r_idx] || r_hold == HOLD_LAST) begin
          w_state_n = IDLE;
          w_gnt_n   = '0;
          w_idx_n   = '0;
          w_hold_n  = '0;
          w_hx_n    = bus.req[r_idx];
        end else begin
          w_hold_n = r_hold + 8'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt          = r_gnt;
    bus.gnt_idx      = r_idx;
    bus.gnt_valid    = |r_gnt;
    bus.hold_expired = r_hx;
  end
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter with MAX_HOLD=4: vector table plus
// hand-written rotation, expiry and reset-mid-grant sequences.
module tb_rr_priority_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  rr_priority_arbiter_if bus();

  rr_priority_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       hx;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] i,
                            input logic v, input logic h);
    chk({tag, ".gnt"}, bus.gnt, g);
    chk({tag, ".idx"}, {5'b0, bus.gnt_idx}, {5'b0, i});
    chk({tag, ".valid"}, {7'b0, bus.gnt_valid}, {7'b0, v});
    chk({tag, ".hx"}, {7'b0, bus.hold_expired}, {7'b0, h});
  endtask

  task automatic drive(input logic r, input logic [7:0] q, input logic m);
    rst         = r;
    bus.req     = q;
    bus.rr_mode = m;
  endtask

  initial begin
    //         rst   req    mode  gnt    idx   v     hx
    vt[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 8'hC1, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 8'hC1, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 8'h41, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vt[12] = '{1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vt[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vt[14] = '{1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vt[15] = '{1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vt[16] = '{1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vt[17] = '{1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vt[18] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

    drive(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst, vt[i].req, vt[i].mode);
      step();
      expect_out($sformatf("vec%0d", i), vt[i].gnt, vt[i].idx, vt[i].valid, vt[i].hx);
    end

    // Round-robin rotation with constant full request.
    drive(1'b1, 8'hFF, 1'b1);
    step();
    expect_out("rr_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 8'hFF, 1'b1);
    for (int k = 0; k < 9; k++) begin
      logic [2:0] e;
      e = 3'(7 - k);
      for (int c = 0; c < 4; c++) begin
        step();
        expect_out($sformatf("rr_g%0d_c%0d", k, c), 8'b1 << e, e, 1'b1, 1'b0);
      end
      step();
      expect_out($sformatf("rr_idle%0d", k), 8'h00, 3'd0, 1'b0, 1'b1);
    end

    // Single requester: expiry, idle, then wrap back to itself.
    drive(1'b1, 8'h01, 1'b1);
    step();
    drive(1'b0, 8'h01, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step();
      expect_out($sformatf("single_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    step();
    expect_out("single_exp", 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    expect_out("single_regrant", 8'h01, 3'd0, 1'b1, 1'b0);

    // Reset during a grant to idx 5, then RR pick must restart from last_idx=0.
    drive(1'b1, 8'h00, 1'b0);
    step();
    drive(1'b0, 8'h20, 1'b0);
    step();
    expect_out("rmg_g0", 8'h20, 3'd5, 1'b1, 1'b0);
    step();
    expect_out("rmg_g1", 8'h20, 3'd5, 1'b1, 1'b0);
    drive(1'b1, 8'h20, 1'b0);
    step();
    expect_out("rmg_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 8'h21, 1'b1);
    step();
    expect_out("rmg_rr", 8'h20, 3'd5, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    step();
    expect_out("rmg_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h21, 1'b1);
    step();
    expect_out("rmg_rot", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
